// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding, reset reload
// constant and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Replicated to WIDTH bits to form the all-ones reset reload value.
  localparam logic RELOAD_RST_BIT = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/counter_down_reload.sv
// Programmable down-counter with one-shot or auto-reload operation and a
// single-cycle registered terminal-count pulse.
module counter_down_reload
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    if (load) begin
      q_nxt      = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else if (stop) begin
      state_nxt = IDLE;
    end else if (state == RUN && en) begin
      // q=0 is only reachable in RUN after an auto-reload terminal count.
      if (q == '0) begin
        q_nxt = reload;
      end else begin
        q_nxt = dec(q);
        if (q == WIDTH'(1)) begin
          tc_nxt = 1'b1;
          if (!auto) state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      reload <= {WIDTH{RELOAD_RST_BIT}};
      tc     <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_down_reload.sv
// Self-checking bench for counter_down_reload: directed scenarios, a randomized
// run against a behavioural model, and an 8-bit period check.
module tb_counter_down_reload;

  logic       clk = 1'b0;
  logic       rst, load, en, auto, stop;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, busy;

  logic       b_rst, b_load, b_en, b_auto, b_stop;
  logic [7:0] b_load_val;
  logic [7:0] b_q;
  logic       b_tc, b_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the 4-bit instance (post-edge values).
  int m_q, m_rel, m_tc;
  bit m_run;

  always #5 clk = ~clk;

  counter_down_reload #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .auto(auto), .stop(stop), .q(q), .tc(tc), .busy(busy)
  );

  counter_down_reload #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(b_rst), .load(b_load), .load_val(b_load_val), .en(b_en),
    .auto(b_auto), .stop(b_stop), .q(b_q), .tc(b_tc), .busy(b_busy)
  );

  task automatic model_next();
    m_tc = 0;
    if (rst) begin
      m_q = 0; m_rel = 15; m_run = 0;
    end else if (load) begin
      m_q = load_val; m_rel = load_val; m_run = (load_val != 0);
    end else if (stop) begin
      m_run = 0;
    end else if (m_run && en) begin
      if (m_q == 0) m_q = m_rel;
      else begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_tc = 1;
          if (!auto) m_run = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit r, bit l, logic [3:0] v, bit e, bit a, bit s);
    rst = r; load = l; load_val = v; en = e; auto = a; stop = s;
  endtask

  task automatic test_reset();
    set_in(1, 1, 4'd7, 1, 1, 0);
    step(); step();
    n_checks++; if (q !== 4'd0) $display("FAIL reset_q: got %0d want 0", q); else n_pass++;
    n_checks++; if (tc !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    set_in(0, 0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
        $display("FAIL idle_hold[%0d]: got q=%0d busy=%b tc=%b want q=0 busy=0 tc=0", i, q, busy, tc);
      else n_pass++;
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    set_in(0, 1, 4'd5, 1, 0, 0);
    step();
    n_checks++;
    if (q !== 4'd5 || busy !== 1'b1 || tc !== 1'b0)
      $display("FAIL oneshot_load: got q=%0d busy=%b tc=%b want q=5 busy=1 tc=0", q, busy, tc);
    else n_pass++;
    load = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (q !== exp_q[i] || tc !== (i == 4) || busy !== (i != 4))
        $display("FAIL oneshot[%0d]: got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=%b",
                 i, q, tc, busy, exp_q[i], (i == 4), (i != 4));
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0)
        $display("FAIL oneshot_after[%0d]: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", i, q, tc, busy);
      else n_pass++;
    end
  endtask

  task automatic test_auto_reload();
    int eq;
    int tcs = 0;
    set_in(0, 1, 4'd3, 1, 1, 0);
    step();
    load = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      eq = (3 - (k % 4) + 4) % 4;
      tcs += int'(tc);
      n_checks++;
      if (q !== 4'(eq) || tc !== (k % 4 == 3) || busy !== 1'b1)
        $display("FAIL auto[%0d]: got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=1",
                 k, q, tc, busy, eq, (k % 4 == 3));
      else n_pass++;
    end
    n_checks++;
    if (tcs !== 3) $display("FAIL auto_tc_count: got %0d want 3", tcs); else n_pass++;
  endtask

  task automatic test_enable_gaps();
    logic [3:0] exp_q [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
    bit         exp_tc [4] = '{0, 0, 1, 0};
    set_in(0, 1, 4'd2, 1, 0, 0);
    step();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      step();
      n_checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i])
        $display("FAIL gaps[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, q, tc, exp_q[i], exp_tc[i]);
      else n_pass++;
    end
    // en drops right after an auto-reload terminal count: tc still one cycle.
    set_in(0, 1, 4'd1, 1, 1, 0);
    step();
    load = 0;
    step();
    en = 0;
    step();
    n_checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b1)
      $display("FAIL gaps_auto_hold: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=1", q, tc, busy);
    else n_pass++;
  endtask

  task automatic test_priority();
    set_in(0, 1, 4'd4, 1, 0, 0);
    step();
    load = 0;
    step(); step(); step();
    set_in(0, 1, 4'd9, 1, 0, 0);
    step();
    n_checks++;
    if (q !== 4'd9 || tc !== 1'b0 || busy !== 1'b1)
      $display("FAIL prio_load_at_tc: got q=%0d tc=%b busy=%b want q=9 tc=0 busy=1", q, tc, busy);
    else n_pass++;
    load = 0;
    step();
    set_in(0, 0, 4'd0, 1, 0, 1);
    step();
    n_checks++;
    if (q !== 4'd8 || tc !== 1'b0 || busy !== 1'b0)
      $display("FAIL prio_stop: got q=%0d tc=%b busy=%b want q=8 tc=0 busy=0", q, tc, busy);
    else n_pass++;
    stop = 0;
    step();
    n_checks++;
    if (q !== 4'd8 || busy !== 1'b0)
      $display("FAIL prio_frozen: got q=%0d busy=%b want q=8 busy=0", q, busy);
    else n_pass++;
    set_in(0, 1, 4'd1, 1, 0, 0);
    step();
    set_in(0, 0, 4'd0, 1, 0, 1);
    step();
    n_checks++;
    if (q !== 4'd1 || tc !== 1'b0 || busy !== 1'b0)
      $display("FAIL prio_stop_over_en: got q=%0d tc=%b busy=%b want q=1 tc=0 busy=0", q, tc, busy);
    else n_pass++;
    set_in(0, 1, 4'd0, 1, 0, 0);
    step();
    n_checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0)
      $display("FAIL prio_load_zero: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", q, tc, busy);
    else n_pass++;
    set_in(0, 1, 4'd6, 1, 0, 0);
    step();
    set_in(1, 1, 4'd5, 1, 1, 0);
    step();
    n_checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0)
      $display("FAIL prio_rst_over_load: got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", q, tc, busy);
    else n_pass++;
    rst = 0; load = 0;
  endtask

  task automatic test_random();
    bit a = 0;
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      if (load) a = $urandom_range(0, 1);
      auto = a;
      stop = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 3) != 0);
      step();
      n_checks++;
      if (q !== 4'(m_q) || tc !== m_tc[0] || busy !== m_run)
        $display("FAIL random[%0d]: got q=%0d tc=%b busy=%b want q=%0d tc=%0d busy=%b",
                 i, q, tc, busy, m_q, m_tc, m_run);
      else n_pass++;
    end
  endtask

  task automatic test_width8();
    int tcs = 0;
    b_rst = 1; b_load = 0; b_load_val = 8'd0; b_en = 1; b_auto = 1; b_stop = 0;
    step();
    b_rst = 0; b_load = 1; b_load_val = 8'd255;
    step();
    b_load = 0;
    n_checks++;
    if (b_q !== 8'd255 || b_busy !== 1'b1)
      $display("FAIL w8_load: got q=%0d busy=%b want q=255 busy=1", b_q, b_busy);
    else n_pass++;
    for (int k = 1; k <= 512; k++) begin
      step();
      tcs += int'(b_tc);
      if (k % 64 == 0 || k % 256 == 255 || k % 256 == 0) begin
        n_checks++;
        if (b_q !== 8'(255 - (k % 256)) || b_tc !== (k % 256 == 255) || b_busy !== 1'b1)
          $display("FAIL w8[%0d]: got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=1",
                   k, b_q, b_tc, b_busy, 255 - (k % 256), (k % 256 == 255));
        else n_pass++;
      end
    end
    n_checks++;
    if (tcs !== 2) $display("FAIL w8_tc_count: got %0d want 2", tcs); else n_pass++;
  endtask

  initial begin
    set_in(0, 0, 4'd0, 0, 0, 0);
    b_rst = 1; b_load = 0; b_load_val = 8'd0; b_en = 0; b_auto = 0; b_stop = 0;
    m_q = 0; m_rel = 15; m_run = 0; m_tc = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gaps();
    test_priority();
    test_random();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
